echo_request_input: RTL and testbench
=====================================

# echo_request_input

Host-to-hardware request demultiplexer for the echo portal. It accepts 32-bit message words from the host-facing request channel and buffers them in a small FIFO. It decodes each header word (method number, word count), assembles the `say` payload and presents it to the Echo core on an ENA/RDY handshake. Malformed or unknown messages are drained and counted.

## Interface
Parameters:
- `DEPTH`, default 4: input FIFO depth in words; must be a power of 2 and at least 2.
- `SAY_METHOD`, default 0: method number decoded as `say`.

Ports:
- `CLK`  in  1  clock.
- `RST_N`  in  1  reset. One clock; reset is synchronous and active-high. The port keeps the codebase name, but the polarity is active-high.
- `requests_0_enq_v`  in  32  host message word.
- `EN_requests_0_enq`  in  1  enqueue strobe; legal only while `RDY_requests_0_enq` is high.
- `RDY_requests_0_enq`  out  1  FIFO can accept a word.
- `requests_0_notFull`  out  1  equals `RDY_requests_0_enq`.
- `RDY_requests_0_notFull`  out  1  constant 1.
- `messageSize_size_methodNumber`  in  16  method number being queried.
- `messageSize_size`  out  16  payload bits for that method.
- `RDY_messageSize_size`  out  1  constant 1.
- `say_v`  out  32  decoded `say` argument.
- `say__ENA`  out  1  a `say` invocation is valid.
- `say__RDY`  in  1  Echo core accepts the invocation.
- `error_count`  out  8  saturating count of dropped messages.

## Operation
- Header word: bits [31:16] hold the method number. Bits [15:0] hold LEN, the total word count including the header.
- A valid `say` message has method == `SAY_METHOD` and LEN == 2.
- `messageSize_size` is 32 when the queried method equals `SAY_METHOD`, otherwise 0. It is combinational.
- FIFO:
  - A word is written on an edge where `EN_requests_0_enq` is high.
  - `RDY_requests_0_enq` = not full and `RST_N` low.
  - There is no bypass: a word written at an edge is first visible to the decoder in the next cycle.
- Decoder FSM: HDR, PAY, ISSUE, DRAIN.
  - HDR: if the FIFO is non-empty, pop the header.
    - Valid `say` header: go to PAY.
    - Otherwise: `error_count`++ (saturates at 255).
    - If LEN ≤ 1, stay in HDR.
    - If LEN > 1, load `remaining` = LEN−1 and go to DRAIN.
  - PAY: if non-empty, pop the word into `say_v` and go to ISSUE.
  - ISSUE: `say__ENA` = 1 and `say_v` is held stable. On an edge with `say__RDY` high, the transfer completes and the FSM goes to HDR. No FIFO pop occurs in ISSUE.
  - DRAIN: pop one word per non-empty cycle and decrement `remaining`. When the pop with `remaining` == 1 occurs, go to HDR.
- Pop and push in the same cycle are both legal, including when the FIFO is full and a pop frees a slot. `RDY_requests_0_enq` is computed from the pre-edge count only, so a full FIFO still reports not ready in that cycle.
- `say__ENA` never deasserts without a handshake, except on reset.

## Timing
- Reset (RST_N high at an edge) sets:
  - FIFO empty, FSM in HDR.
  - `say__ENA` = 0, `say_v` = 0, `error_count` = 0.
  - `RDY_requests_0_enq` = 0 while reset is held, and 1 in the first cycle after release.
- Reset mid-message discards any partial message and any pending `say` with no transfer. Reset wins over a simultaneous `say__RDY`.
- Latency for back-to-back enqueues: header enqueued at edge E0, payload at E1. The decoder pops the header at E1 and the payload at E2. `say__ENA` is high in the cycle after E2.
- Throughput: at most one `say` per 3 cycles, with `say__RDY` tied high.
- `say_v` and `say__ENA` are registered outputs. `RDY_requests_0_enq` is registered-count-derived, with no combinational path from `EN_requests_0_enq`.
- LEN field is 16-bit unsigned. `remaining` is 16 bits and never wraps below 1 in DRAIN.

## Structure
- Shared package `echo_portal_pkg` holds:
  - the FSM state enum;
  - the header field positions and `SAY_METHOD_LEN` = 2;
  - `SAY_PAYLOAD_BITS` = 32.
  - The indication-side output block uses the same header layout and must import it from this package.
- One sub-module: `portal_word_fifo`, a parameterized synchronous FIFO with full/empty flags and registered count.

## Test plan
- Reset release, then enqueue `0x0000_0002` and `0xDEAD_BEEF` on consecutive cycles, with `say__RDY` = 1 → `say__ENA` is high for exactly one cycle, 3 cycles after the header edge, with `say_v` = `0xDEADBEEF`; `error_count` = 0.
- Same message with `say__RDY` held low for 5 cycles → `say__ENA` and `say_v` are stable for all 5 cycles; the transfer occurs on the first `say__RDY` edge.
- Enqueue header `0x0001_0003` plus 2 words, then a valid `say` with 0x12345678 → the 2 words are drained, `error_count` = 1, and exactly one `say` with 0x12345678 follows.
- `say__RDY` = 0 while the host streams 6 words with DEPTH = 4 → `RDY_requests_0_enq` drops after the FIFO fills. After `say__RDY` rises, all words are delivered in order and none are lost.
- Headers `0x0000_0000` and `0x0000_0001` → each increments `error_count` with no drain and no `say`. 256 bad headers → `error_count` saturates at 255.
- Assert `RST_N` in the cycle after the payload enqueue → no `say__ENA`, the FIFO is empty, and the next valid message decodes normally.

Source files
------------

// File: rtl/echo_portal_pkg.sv
// Shared definitions for the echo portal: decoder states, header layout and
// method sizing, used by both the request and indication sides.
package echo_portal_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned HDR_METHOD_LSB   = 16;
  localparam int unsigned HDR_METHOD_W     = 16;
  localparam int unsigned HDR_LEN_LSB      = 0;
  localparam int unsigned HDR_LEN_W        = 16;
  localparam int unsigned SAY_METHOD_LEN   = 2;
  localparam int unsigned SAY_PAYLOAD_BITS = 32;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAY,
    ST_ISSUE,
    ST_DRAIN
  } dec_state_e;

  typedef struct packed {
    logic [HDR_METHOD_W-1:0] method;
    logic [HDR_LEN_W-1:0]    len;
  } msg_hdr_t;

  function automatic msg_hdr_t unpack_hdr(input logic [WORD_W-1:0] w);
    msg_hdr_t h;
    h.method = w[HDR_METHOD_LSB +: HDR_METHOD_W];
    h.len    = w[HDR_LEN_LSB +: HDR_LEN_W];
    return h;
  endfunction

endpackage

// File: rtl/portal_word_fifo.sv
// Synchronous word FIFO with a registered occupancy count; read data is the
// current head word (no bypass from the write port).
module portal_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_c;
  logic             pop_c;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign pop_c   = pop_i && !empty_c;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign push_c  = push_i && (!full_c || pop_c);
  assign rdata_c = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/echo_request_input.sv
// Request-side demultiplexer: buffers host words, decodes headers, issues
// `say` to the Echo core and drains/counts anything malformed.
module echo_request_input
  import echo_portal_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SAY_METHOD = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] requests_0_enq_v,
  input  logic        EN_requests_0_enq,
  output logic        RDY_requests_0_enq,
  output logic        requests_0_notFull,
  output logic        RDY_requests_0_notFull,
  input  logic [15:0] messageSize_size_methodNumber,
  output logic [15:0] messageSize_size,
  output logic        RDY_messageSize_size,
  output logic [31:0] say_v,
  output logic        say__ENA,
  input  logic        say__RDY,
  output logic [7:0]  error_count
);

  dec_state_e        state_q, state_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [31:0]       say_v_q, say_v_d;
  logic              say_ena_q, say_ena_d;
  logic [7:0]        err_q, err_d;
  logic              pop_c;
  logic [WORD_W-1:0] fifo_rdata_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  msg_hdr_t          hdr_c;

  portal_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST_N),
    .push_i  (EN_requests_0_enq),
    .wdata_i (requests_0_enq_v),
    .pop_i   (pop_c),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign RDY_requests_0_enq     = !fifo_full_c && !RST_N;
  assign requests_0_notFull     = RDY_requests_0_enq;
  assign RDY_requests_0_notFull = 1'b1;
  assign RDY_messageSize_size   = 1'b1;
  assign messageSize_size       = (messageSize_size_methodNumber == 16'(SAY_METHOD))
                                  ? 16'(SAY_PAYLOAD_BITS) : 16'd0;
  assign say_v       = say_v_q;
  assign say__ENA    = say_ena_q;
  assign error_count = err_q;

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state_q     <= ST_HDR;
      remaining_q <= '0;
      say_v_q     <= '0;
      say_ena_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      say_v_q     <= say_v_d;
      say_ena_q   <= say_ena_d;
      err_q       <= err_d;
    end
  end

  // Decoder: one pop per cycle in HDR/PAY/DRAIN, none while a say is pending.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    say_v_d     = say_v_q;
    say_ena_d   = say_ena_q;
    err_d       = err_q;
    pop_c       = 1'b0;
    hdr_c       = unpack_hdr(fifo_rdata_c);
    case (state_q)
      ST_HDR: begin
        if (!fifo_empty_c) begin
          pop_c = 1'b1;
          if (hdr_c.method == 16'(SAY_METHOD) && hdr_c.len == 16'(SAY_METHOD_LEN)) begin
            state_d = ST_PAY;
          end else begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (hdr_c.len > 16'd1) begin
              remaining_d = hdr_c.len - 16'd1;
              state_d     = ST_DRAIN;
            end
          end
        end
      end
      ST_PAY: begin
        if (!fifo_empty_c) begin
          pop_c     = 1'b1;
          say_v_d   = fifo_rdata_c;
          say_ena_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (say__RDY) begin
          say_ena_d = 1'b0;
          state_d   = ST_HDR;
        end
      end
      ST_DRAIN: begin
        if (!fifo_empty_c) begin
          pop_c = 1'b1;
          if (remaining_q == 16'd1) begin
            state_d = ST_HDR;
          end else begin
            remaining_d = remaining_q - 16'd1;
          end
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

endmodule

// File: tb/tb_echo_request_input.sv
// Directed bench for echo_request_input: cycle vector table plus hand-written
// sequences for back-pressure, drain, saturation and mid-message reset.
module tb_echo_request_input;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] requests_0_enq_v;
  logic        EN_requests_0_enq;
  logic        RDY_requests_0_enq;
  logic        requests_0_notFull;
  logic        RDY_requests_0_notFull;
  logic [15:0] messageSize_size_methodNumber;
  logic [15:0] messageSize_size;
  logic        RDY_messageSize_size;
  logic [31:0] say_v;
  logic        say__ENA;
  logic        say__RDY;
  logic [7:0]  error_count;

  int tests = 0;
  int fails = 0;

  echo_request_input #(.DEPTH(4), .SAY_METHOD(0)) dut (
    .CLK                           (CLK),
    .RST_N                         (RST_N),
    .requests_0_enq_v              (requests_0_enq_v),
    .EN_requests_0_enq             (EN_requests_0_enq),
    .RDY_requests_0_enq            (RDY_requests_0_enq),
    .requests_0_notFull            (requests_0_notFull),
    .RDY_requests_0_notFull        (RDY_requests_0_notFull),
    .messageSize_size_methodNumber (messageSize_size_methodNumber),
    .messageSize_size              (messageSize_size),
    .RDY_messageSize_size          (RDY_messageSize_size),
    .say_v                         (say_v),
    .say__ENA                      (say__ENA),
    .say__RDY                      (say__RDY),
    .error_count                   (error_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        en;
    logic [31:0] d;
    logic        rdy;
    logic        exp_ena;
    logic [31:0] exp_v;
    logic [7:0]  exp_err;
    logic        exp_rdy_enq;
  } vec_t;

  typedef struct {
    logic [15:0] method;
    logic [15:0] exp_size;
  } size_vec_t;

  vec_t        vecs [9];
  size_vec_t   svecs [4];
  logic [31:0] got [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic push(input logic [31:0] w);
    int guard = 0;
    while (!RDY_requests_0_enq && guard < 50) begin
      step();
      guard++;
    end
    check("push_ready_timeout", 32'(guard >= 50), 32'd0);
    EN_requests_0_enq = 1'b1;
    requests_0_enq_v  = w;
    step();
    EN_requests_0_enq = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b1;
    step();
    check("rst_rdy_enq", 32'(RDY_requests_0_enq), 32'd0);
    check("rst_ena", 32'(say__ENA), 32'd0);
    check("rst_say_v", say_v, 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    RST_N = 1'b0;
    step();
    check("post_rst_rdy_enq", 32'(RDY_requests_0_enq), 32'd1);
  endtask

  // Records every accepted say (ENA high while RDY is driven high).
  task automatic collect(input int cycles);
    say__RDY = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (say__ENA) got.push_back(say_v);
      step();
    end
  endtask

  initial begin
    RST_N = 1'b1;
    requests_0_enq_v = '0;
    EN_requests_0_enq = 1'b0;
    say__RDY = 1'b1;
    messageSize_size_methodNumber = '0;

    // en, data, rdy, exp_ena, exp_say_v, exp_err, exp_rdy_enq
    vecs[0] = '{1'b1, 32'h0000_0002, 1'b1, 1'b0, 32'h0,         8'd0, 1'b1};
    vecs[1] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         8'd0, 1'b1};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 8'd0, 1'b1};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 8'd0, 1'b1};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 8'd0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 8'd0, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'hDEAD_BEEF, 8'd1, 1'b1};
    vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 8'd2, 1'b1};
    vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 8'd2, 1'b1};

    svecs[0] = '{16'h0000, 16'd32};
    svecs[1] = '{16'h0001, 16'd0};
    svecs[2] = '{16'hFFFF, 16'd0};
    svecs[3] = '{16'h0002, 16'd0};

    @(negedge CLK);
    do_reset();
    check("notfull_const", 32'(RDY_requests_0_notFull), 32'd1);
    check("size_rdy_const", 32'(RDY_messageSize_size), 32'd1);

    for (int i = 0; i < 4; i++) begin
      messageSize_size_methodNumber = svecs[i].method;
      #1;
      check($sformatf("msg_size[%0d]", i), 32'(messageSize_size), 32'(svecs[i].exp_size));
    end

    // Basic say latency followed by two short bad headers.
    for (int i = 0; i < 9; i++) begin
      EN_requests_0_enq = vecs[i].en;
      requests_0_enq_v  = vecs[i].d;
      say__RDY          = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_ena", i), 32'(say__ENA), 32'(vecs[i].exp_ena));
      check($sformatf("vec%0d_say_v", i), say_v, vecs[i].exp_v);
      check($sformatf("vec%0d_err", i), 32'(error_count), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdy_enq", i), 32'(RDY_requests_0_enq), 32'(vecs[i].exp_rdy_enq));
    end
    EN_requests_0_enq = 1'b0;

    // Back-pressure: say held stable while RDY is low.
    do_reset();
    say__RDY = 1'b0;
    push(32'h0000_0002);
    push(32'hDEAD_BEEF);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_ena", i), 32'(say__ENA), 32'd1);
      check($sformatf("hold%0d_say_v", i), say_v, 32'hDEAD_BEEF);
      step();
    end
    say__RDY = 1'b1;
    step();
    check("hold_release_ena", 32'(say__ENA), 32'd0);

    // Unknown 3-word message is drained, then a valid say follows.
    do_reset();
    say__RDY = 1'b1;
    got.delete();
    push(32'h0001_0003);
    push(32'h1111_1111);
    push(32'h0000_0002);
    push(32'h0000_0002);
    push(32'h1234_5678);
    collect(15);
    check("drain_err", 32'(error_count), 32'd1);
    check("drain_say_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("drain_say_v", got[0], 32'h1234_5678);

    // Host streams six words while the core stalls.
    do_reset();
    say__RDY = 1'b0;
    got.delete();
    push(32'h0000_0002);
    push(32'h0000_00A0);
    push(32'h0000_0002);
    push(32'h0000_00A1);
    push(32'h0000_0002);
    push(32'h0000_00A2);
    check("stream_full_rdy", 32'(RDY_requests_0_enq), 32'd0);
    check("stream_full_notfull", 32'(requests_0_notFull), 32'd0);
    check("stream_stall_ena", 32'(say__ENA), 32'd1);
    collect(20);
    check("stream_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check($sformatf("stream_word%0d", i), got[i], 32'h0000_00A0 + 32'(i));
    end
    check("stream_err", 32'(error_count), 32'd0);

    // Error counter saturation.
    do_reset();
    say__RDY = 1'b1;
    for (int i = 0; i < 256; i++) push(32'h0000_0000);
    step();
    step();
    check("err_saturate", 32'(error_count), 32'd255);
    check("err_sat_no_say", 32'(say__ENA), 32'd0);

    // Reset right after the payload enqueue discards the message.
    RST_N = 1'b1;
    step();
    RST_N = 1'b0;
    step();
    say__RDY = 1'b1;
    push(32'h0000_0002);
    push(32'h5555_AAAA);
    RST_N = 1'b1;
    step();
    check("midrst_ena", 32'(say__ENA), 32'd0);
    check("midrst_say_v", say_v, 32'd0);
    check("midrst_rdy_enq", 32'(RDY_requests_0_enq), 32'd0);
    RST_N = 1'b0;
    got.delete();
    collect(5);
    check("midrst_no_say", 32'(got.size()), 32'd0);
    check("midrst_err", 32'(error_count), 32'd0);
    push(32'h0000_0002);
    push(32'hCAFE_F00D);
    collect(6);
    check("midrst_next_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("midrst_next_v", got[0], 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
